// File: rtl/seq_det_ctrl.sv
// Sequencer for a serial sequence detector: resets it, shifts a pattern in MSB-first and
// collects the detector's response into a per-bit match mask and a saturating match count.
module seq_det_ctrl #(
  parameter int unsigned W       = 8,
  parameter int unsigned LW      = 4,
  parameter int unsigned CW      = 4,
  parameter int unsigned DET_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  pat_word,
  input  logic [LW-1:0] pat_len,
  input  logic          det_out,
  output logic          det_in,
  output logic          det_rst,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] match_cnt,
  output logic [W-1:0]  match_mask
);

  localparam int unsigned   IW        = (W > 1) ? $clog2(W) : 1;
  localparam logic [LW-1:0] LenMax    = LW'(W);
  localparam logic [2:0]    DrainLast = 3'(DET_LAT - 1);

  typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StDone} state_e;

  state_e        r_state;
  logic [W-1:0]  r_shift;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_bitcnt;
  logic [2:0]    r_drain;
  logic          r_det_in;
  logic          r_det_rst;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_mask;
  // Stage 0 tracks the bit currently on det_in; stage DET_LAT is the one sampled this edge.
  logic [DET_LAT:0] r_vld;
  logic [IW-1:0]    r_idx [DET_LAT+1];

  logic [LW-1:0] w_len;
  logic          w_run;
  logic          w_sample;

  assign w_len    = (pat_len > LenMax) ? LenMax : pat_len;
  assign w_run    = (r_state == StClear) || (r_state == StShift) || (r_state == StDrain);
  assign w_sample = r_vld[DET_LAT] && ((r_state == StShift) || (r_state == StDrain));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_len     <= '0;
      r_bitcnt  <= '0;
      r_drain   <= '0;
      r_det_in  <= 1'b0;
      r_det_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_vld     <= '0;
      for (int i = 0; i <= DET_LAT; i++) r_idx[i] <= '0;
    end else begin
      r_vld  <= {r_vld[DET_LAT-1:0], 1'b0};
      r_done <= 1'b0;
      for (int i = 1; i <= DET_LAT; i++) r_idx[i] <= r_idx[i-1];

      if (w_sample && det_out) begin
        r_mask[r_idx[DET_LAT]] <= 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
      end

      if (abort && w_run) begin
        // Results keep their partial values; the detector is reset for one cycle.
        r_state   <= StIdle;
        r_det_rst <= 1'b1;
        r_det_in  <= 1'b0;
        r_busy    <= 1'b0;
        r_vld     <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_det_rst <= 1'b0;
            r_det_in  <= 1'b0;
            if (start) begin
              r_shift  <= pat_word;
              r_len    <= w_len;
              r_bitcnt <= '0;
              r_cnt    <= '0;
              r_mask   <= '0;
              r_busy   <= 1'b1;
              if (w_len == '0) begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end else begin
                r_state   <= StClear;
                r_det_rst <= 1'b1;
              end
            end
          end
          StClear: begin
            r_det_rst <= 1'b0;
            r_det_in  <= r_shift[W-1];
            r_shift   <= r_shift << 1;
            r_bitcnt  <= LW'(1);
            r_vld[0]  <= 1'b1;
            r_idx[0]  <= '0;
            r_state   <= StShift;
          end
          StShift: begin
            if (r_bitcnt == r_len) begin
              r_det_in <= 1'b0;
              r_drain  <= '0;
              r_state  <= StDrain;
            end else begin
              r_det_in <= r_shift[W-1];
              r_shift  <= r_shift << 1;
              r_bitcnt <= r_bitcnt + LW'(1);
              r_vld[0] <= 1'b1;
              r_idx[0] <= r_bitcnt[IW-1:0];
            end
          end
          StDrain: begin
            r_det_in <= 1'b0;
            if (r_drain == DrainLast) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_drain <= r_drain + 3'd1;
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign det_in     = r_det_in;
  assign det_rst    = r_det_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign match_cnt  = r_cnt;
  assign match_mask = r_mask;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: an overlapping "011" Moore detector model on the detector pins and a
// scoreboard of expected run results pushed at each start and popped at the done pulse.
module tb_seq_det_ctrl;
  localparam int W = 8, LW = 4, CW = 4, DET_LAT = 1;

  logic          clk = 1'b0;
  logic          reset, start, abort, det_out, det_in, det_rst, busy, done;
  logic [W-1:0]  pat_word, match_mask;
  logic [LW-1:0] pat_len;
  logic [CW-1:0] match_cnt;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [W-1:0]  mask;
    logic [7:0]    lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_det_ctrl #(.W(W), .LW(LW), .CW(CW), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pat_word(pat_word),
    .pat_len(pat_len), .det_out(det_out), .det_in(det_in), .det_rst(det_rst), .busy(busy),
    .done(done), .match_cnt(match_cnt), .match_mask(match_mask)
  );

  always #5 clk = ~clk;

  // Detector: S0 none, S1 "0", S2 "01", S3 "011" (output high)
  logic [1:0] det_st = 2'd0;
  always @(posedge clk) begin
    if (det_rst) det_st <= 2'd0;
    else begin
      case (det_st)
        2'd0:    det_st <= det_in ? 2'd0 : 2'd1;
        2'd1:    det_st <= det_in ? 2'd2 : 2'd1;
        2'd2:    det_st <= det_in ? 2'd3 : 2'd1;
        default: det_st <= det_in ? 2'd0 : 2'd1;
      endcase
    end
  end
  assign det_out = (det_st == 2'd3);

  function automatic exp_t model(input logic [W-1:0] pat, input logic [LW-1:0] len);
    exp_t e;
    int   l;
    logic b [W];
    e = '0;
    l = (int'(len) > W) ? W : int'(len);
    for (int k = 0; k < W; k++) b[k] = pat[W-1-k];
    for (int k = 2; k < l; k++) begin
      if (!b[k-2] && b[k-1] && b[k]) begin
        e.mask[k] = 1'b1;
        e.cnt     = e.cnt + 4'd1;
      end
    end
    e.lat = (l == 0) ? 8'd0 : 8'(l + 1 + DET_LAT);
    return e;
  endfunction

  // Leaves the bench at the falling edge right after the start edge (t = 0).
  task automatic do_start(input logic [W-1:0] pat, input logic [LW-1:0] len, input bit push);
    pat_word = pat;
    pat_len  = len;
    start    = 1'b1;
    if (push) sb.push_back(model(pat, len));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes t = 0..max_t; optionally pulses start while the run is in progress.
  task automatic monitor(input int l, input int max_t, input bit poke, output int t_done,
                         output int n_done, output int n_rst, output logic [W-1:0] shifted,
                         output logic [CW-1:0] c_cnt, output logic [W-1:0] c_mask);
    t_done = -1; n_done = 0; n_rst = 0; shifted = '0; c_cnt = '0; c_mask = '0;
    for (int t = 0; t <= max_t; t++) begin
      if (t > 0) @(negedge clk);
      if (poke) begin
        start    = (t == 1 || t == 3 || t == 5 || t == 7);
        pat_word = W'($urandom);
        pat_len  = 4'd3;
      end
      if (det_rst) n_rst++;
      if (t >= 1 && t <= l) shifted[W-t] = det_in;
      if (done) begin
        n_done++;
        if (t_done < 0) begin
          t_done = t;
          c_cnt  = match_cnt;
          c_mask = match_mask;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; pat_word = '0; pat_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, det_rst, det_in, match_cnt, match_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero",
               {busy, done, det_rst, det_in, match_cnt, match_mask});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full-run scenario shared by the basic, clamp and start-ignored cases.
  task automatic test_run(input string nm, input logic [W-1:0] pat, input logic [LW-1:0] len,
                          input bit poke);
    int t_done, n_done, n_rst, l;
    logic [W-1:0] sh, c_mask, ones;
    logic [CW-1:0] c_cnt;
    exp_t e;
    l = (int'(len) > W) ? W : int'(len);
    do_start(pat, len, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy: got %b want 1", nm, busy);
    end
    monitor(l, 20, poke, t_done, n_done, n_rst, sh, c_cnt, c_mask);
    e = sb.pop_front();
    ones = '1;
    checks++;
    if (t_done != int'(e.lat)) begin
      errors++; $display("FAIL %s_latency: got %0d want %0d", nm, t_done, e.lat);
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL %s_done_pulses: got %0d want 1", nm, n_done);
    end
    checks++;
    if (n_rst != ((l == 0) ? 0 : 1)) begin
      errors++; $display("FAIL %s_det_rst_cycles: got %0d want %0d", nm, n_rst, (l == 0) ? 0 : 1);
    end
    checks++;
    if (sh !== (pat & ~(ones >> l))) begin
      errors++; $display("FAIL %s_det_in_seq: got %b want %b", nm, sh, pat & ~(ones >> l));
    end
    checks++;
    if (c_cnt !== e.cnt || c_mask !== e.mask) begin
      errors++;
      $display("FAIL %s_result: got cnt %0d mask %b want cnt %0d mask %b", nm, c_cnt, c_mask,
               e.cnt, e.mask);
    end
    checks++;
    if (busy !== 1'b0 || match_cnt !== e.cnt || match_mask !== e.mask) begin
      errors++;
      $display("FAIL %s_hold: got busy %b cnt %0d mask %b want busy 0 cnt %0d mask %b", nm, busy,
               match_cnt, match_mask, e.cnt, e.mask);
    end
  endtask

  task automatic test_abort();
    int t_done, n_done, n_rst;
    logic [W-1:0] sh, c_mask;
    logic [CW-1:0] c_cnt;
    do_start(8'b01101101, 4'd8, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || det_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got busy %b det_rst %b done %b want 0 1 0", busy, det_rst, done);
    end
    checks++;
    if (match_cnt !== 4'd1 || match_mask !== 8'b00000100) begin
      errors++;
      $display("FAIL abort_partial: got cnt %0d mask %b want cnt 1 mask 00000100", match_cnt,
               match_mask);
    end
    monitor(0, 12, 1'b0, t_done, n_done, n_rst, sh, c_cnt, c_mask);
    checks++;
    if (n_done != 0 || n_rst != 1) begin
      errors++;
      $display("FAIL abort_after: got done %0d det_rst %0d want 0 1", n_done, n_rst);
    end
    test_run("abort_rerun", 8'b01101101, 4'd8, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_start(8'b01101101, 4'd8, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, det_rst, det_in, match_cnt, match_mask} !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain: got %b want all zero",
               {busy, done, det_rst, det_in, match_cnt, match_mask});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_coincident();
    int t_done, n_done, n_rst;
    logic [W-1:0] sh, c_mask;
    logic [CW-1:0] c_cnt;
    exp_t e;
    do_start(8'b01101101, 4'd8, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || det_rst !== 1'b1) begin
      errors++; $display("FAIL abort_wins: got busy %b det_rst %b want 0 1", busy, det_rst);
    end
    monitor(0, 12, 1'b0, t_done, n_done, n_rst, sh, c_cnt, c_mask);
    checks++;
    if (n_done != 0) begin
      errors++; $display("FAIL abort_wins_no_done: got %0d want 0", n_done);
    end
    // Hold start across the DONE cycle of a zero-length run.
    pat_word = 8'hff; pat_len = 4'd0; start = 1'b1;
    sb.push_back(model(8'hff, 4'd0));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || match_cnt !== e.cnt || match_mask !== e.mask) begin
      errors++;
      $display("FAIL done_cycle_first: got done %b cnt %0d mask %b want 1 %0d %b", done,
               match_cnt, match_mask, e.cnt, e.mask);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_in_done: got done %b busy %b want 0 0", done, busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run("basic", 8'b01101101, 4'd8, 1'b0);
    test_run("len5", 8'b01110110, 4'd5, 1'b0);
    test_run("len0", 8'b01101101, 4'd0, 1'b0);
    test_run("len15", 8'b01101101, 4'd15, 1'b0);
    test_run("start_ignored", 8'b01101101, 4'd8, 1'b1);
    test_run("random", W'($urandom), LW'($urandom_range(1, W)), 1'b0);
    test_abort();
    test_reset_mid();
    test_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Controller that sequences a serial sequence-detector block.
- Takes a parallel test pattern and its length, then resets the detector.
- Shifts the pattern into the detector MSB-first, one bit per clock.
- Samples the detector's output with a fixed latency, then reports a match count and a per-bit match mask.
- Sits between a host/CPU-style command interface and the detector's clk/reset/in/out pins.

Parameters:
W, 8, maximum pattern length in bits; also the width of pat_word and match_mask
LW, 4, width of pat_len; must satisfy 2^LW > W
CW, 4, width of match_cnt; must satisfy 2^CW > W
DET_LAT, 1, number of clock edges after the detector consumes bit k until det_out for bit k is sampled (allowed range 1..4)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  command strobe; honoured only in IDLE
abort  input  1  cancels a run in progress
pat_word  input  W  pattern; bit W-1 is shifted first
pat_len  input  LW  number of bits to shift; values above W clamp to W
det_out  input  1  detector output
det_in  output  1  serial bit to detector
det_rst  output  1  detector reset (active-high)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
match_cnt  output  CW  number of sampled det_out=1 events in the last run; saturates at 2^CW-1
match_mask  output  W  bit k set if det_out sampled for pattern bit k was 1 (k=0 is the first bit shifted)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pattern and counter registers 0.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE. All outputs are registered.
- IDLE:
  - On start=1 at edge E0: latch pat_word; latch L = min(pat_len, W); clear match_cnt and match_mask.
  - If L=0, go to DONE; otherwise go to CLEAR.
- CLEAR (one cycle, E0..E1): det_rst=1, det_in=0.
- SHIFT (L cycles, E1..E_{L+1}):
  - det_in is the current MSB of the shift register.
  - The shift register moves left by one each cycle.
  - The bit counter increments until L bits have been driven, then the FSM goes to DRAIN.
- Sampling:
  - Bit k is driven during E_{k+1}..E_{k+2} and consumed by the detector at E_{k+2}.
  - The controller samples det_out for bit k at edge E_{k+2+DET_LAT}.
  - Implement with a DET_LAT-deep valid/index pipeline.
  - On a valid sample with det_out=1: match_mask[k]<=1 and match_cnt increments, saturating.
  - Samples are never taken in IDLE, CLEAR or DONE, nor after an abort.
- DRAIN: lasts DET_LAT cycles with det_in=0; then the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, visible after edge E_{L+1+DET_LAT}; then IDLE.
  - The last sample lands on the same edge, so final match_cnt and match_mask are visible together with done.
  - For L=0: done=1 in the cycle after E0, with match_cnt=0.
- Results hold until the next accepted start.
- start while busy=1 is ignored entirely; no queuing.
- abort=1 in CLEAR, SHIFT or DRAIN:
  - Next state is IDLE, with det_rst=1 for that one cycle.
  - done is not pulsed; match_cnt and match_mask keep their partial values.
  - abort in IDLE or DONE has no effect.
- Simultaneous events:
  - abort and start in the same cycle while busy: abort wins.
  - start in the DONE cycle: ignored.
- reset asserted mid-run: the next edge returns all state and outputs to reset values, including det_rst=0.

Test Plan:
The bench models the detector as an overlapping "011" Moore detector with registered output, and uses DET_LAT=1.
1. Reset, then start with pat_word=8'b01101101, pat_len=8 -> det_in sequence 0,1,1,0,1,1,0,1; det_rst high for 1 cycle; done 10 cycles after the start edge; match_cnt=2; match_mask=8'b00100100.
2. pat_word=8'b01110110, pat_len=5 -> shifts 0,1,1,1,0; match_cnt=1; match_mask=8'b00000100; done 7 cycles after start.
3. pat_len=0 -> no det_rst, no shifting; done the cycle after start; match_cnt=0; mask=0. Then pat_len=15 -> clamps to 8; behaves as scenario 1.
4. Pulse start repeatedly during a run -> ignored; exactly one done pulse; results identical to scenario 1.
5. abort in the 4th SHIFT cycle of scenario 1 -> IDLE next cycle; det_rst=1 for one cycle; no done; busy=0; a new start then runs cleanly to done.
6. Synchronous reset asserted during DRAIN -> all outputs 0 after the edge; start/abort/start coincident cases: abort wins; start in DONE is dropped.
